// File: rtl/pe_fifo_pkg.sv
// pe_fifo_pkg: shared element type and pointer/keep helpers for the PE output FIFO
package pe_fifo_pkg;
    localparam int PE_WIDTH = 4;

    typedef logic [PE_WIDTH-1:0] elem_t;

    // Capacity need not be a power of two, so wrap by a single compare/subtract.
    // Callers guarantee ptr < cap and inc < cap.
    function automatic int wrap_add(input int ptr, input int inc, input int cap);
        return (ptr + inc >= cap) ? ptr + inc - cap : ptr + inc;
    endfunction

    function automatic int popcount(input logic [31:0] m);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m[i]);
        return n;
    endfunction
endpackage

// File: rtl/pe_fifo_ring.sv
// pe_fifo_ring: element-granular circular buffer with multi-lane write and read windows
module pe_fifo_ring #(
    parameter int WIDTH    = 4,
    parameter int WR_LANES = 2,
    parameter int RD_LANES = 4,
    parameter int CAP      = 8
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_wr_en,
    input  logic [$clog2(WR_LANES+1)-1:0]          i_wr_cnt,
    input  logic [WR_LANES-1:0][WIDTH-1:0]         i_wr_dat,
    input  logic                                   i_rd_en,
    input  logic [$clog2(CAP+1)-1:0]               i_rd_cnt,
    output logic [RD_LANES-1:0][WIDTH-1:0]         o_rd_dat
);
    import pe_fifo_pkg::*;

    localparam int PW = $clog2(CAP);

    logic [WIDTH-1:0] r_mem [CAP];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW-1:0]    w_widx [WR_LANES];

    // Per-lane write slots and the read window starting at the read pointer
    always_comb begin
        for (int i = 0; i < WR_LANES; i++) w_widx[i] = PW'(wrap_add(int'(r_wptr), i, CAP));
        for (int i = 0; i < RD_LANES; i++) o_rd_dat[i] = r_mem[PW'(wrap_add(int'(r_rptr), i, CAP))];
    end

    // Storage is never reset; only lanes below the push count are written
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < WR_LANES; i++)
            if (i_wr_en && i < int'(i_wr_cnt)) r_mem[w_widx[i]] <= i_wr_dat[i];
    end

    // Pointers advance by the number of elements moved, wrapping at CAP
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_wr_en) r_wptr <= PW'(wrap_add(int'(r_wptr), int'(i_wr_cnt), CAP));
            if (i_rd_en) r_rptr <= PW'(wrap_add(int'(r_rptr), int'(i_rd_cnt), CAP));
        end
    end
endmodule

// File: rtl/pe_out_gather_fifo.sv
// pe_out_gather_fifo: gathers 0..WR_LANES elements per cycle and emits RD_LANES-wide words with flush/keep
module pe_out_gather_fifo #(
    parameter int WIDTH    = 4,
    parameter int WR_LANES = 2,
    parameter int RD_LANES = 4,
    parameter int DEPTH    = 2
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_in_vld,
    input  logic [$clog2(WR_LANES+1)-1:0]          i_in_cnt,
    input  logic [WR_LANES-1:0][WIDTH-1:0]         i_in_dat,
    output logic                                   o_in_rdy,
    output logic                                   o_out_vld,
    output logic [RD_LANES-1:0][WIDTH-1:0]         o_out_dat,
    output logic [RD_LANES-1:0]                    o_out_keep,
    input  logic                                   i_out_rdy,
    input  logic                                   i_flush,
    output logic [$clog2(DEPTH*RD_LANES+1)-1:0]    o_lvl,
    output logic                                   o_err_ovf,
    input  logic                                   i_err_clr
);
    import pe_fifo_pkg::*;

    localparam int CAP = DEPTH * RD_LANES;
    localparam int CW  = $clog2(WR_LANES + 1);
    localparam int LW  = $clog2(CAP + 1);

    logic [LW-1:0]                 r_cnt;
    logic                          r_err;
    logic                          w_full;
    logic                          w_part;
    logic                          w_push;
    logic                          w_bad;
    logic                          w_pop;
    logic [LW-1:0]                 w_push_n;
    logic [LW-1:0]                 w_pop_n;
    logic [RD_LANES-1:0]           w_keep;
    logic [RD_LANES-1:0][WIDTH-1:0] w_rd_dat;

    pe_fifo_ring #(
        .WIDTH    (WIDTH),
        .WR_LANES (WR_LANES),
        .RD_LANES (RD_LANES),
        .CAP      (CAP)
    ) u_ring (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_wr_en  (w_push),
        .i_wr_cnt (i_in_cnt),
        .i_wr_dat (i_in_dat),
        .i_rd_en  (w_pop),
        .i_rd_cnt (w_pop_n),
        .o_rd_dat (w_rd_dat)
    );

    // Handshakes, keep mask and element counts; readiness looks only at the registered count
    always_comb begin
        o_in_rdy  = r_cnt <= LW'(CAP - WR_LANES);
        w_full    = r_cnt >= LW'(RD_LANES);
        w_part    = i_flush && r_cnt != '0 && !w_full;
        for (int i = 0; i < RD_LANES; i++) begin
            w_keep[i]    = w_full || (w_part && LW'(i) < r_cnt);
            o_out_dat[i] = w_keep[i] ? w_rd_dat[i] : '0;
        end
        o_out_vld  = w_full || w_part;
        o_out_keep = w_keep;
        w_pop      = o_out_vld && i_out_rdy;
        w_pop_n    = w_pop ? LW'(popcount(32'(w_keep))) : '0;
        w_bad      = i_in_vld && (!o_in_rdy || i_in_cnt > CW'(WR_LANES));
        w_push     = i_in_vld && !w_bad && i_in_cnt != '0;
        w_push_n   = w_push ? LW'(i_in_cnt) : '0;
        o_lvl      = r_cnt;
        o_err_ovf  = r_err;
    end

    // Count tracks push minus pop; overflow flag is sticky with set over clear
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= r_cnt + w_push_n - w_pop_n;
            r_err <= w_bad || (r_err && !i_err_clr);
        end
    end
endmodule

// File: tb/tb_pe_out_gather_fifo.sv
// tb_pe_out_gather_fifo: directed checks of the gather FIFO at CAP=8 and CAP=12
module tb_pe_out_gather_fifo;
    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_vld;
    logic [1:0]       in_cnt;
    logic [1:0][3:0]  in_dat;
    logic             out_rdy;
    logic             flush;
    logic             err_clr;

    logic             in_rdy, out_vld, err_ovf;
    logic [3:0][3:0]  out_dat;
    logic [3:0]       out_keep;
    logic [3:0]       lvl;

    logic             in_rdy12, out_vld12, err_ovf12;
    logic [3:0][3:0]  out_dat12;
    logic [3:0]       out_keep12;
    logic [3:0]       lvl12;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pe_out_gather_fifo u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_vld(in_vld), .i_in_cnt(in_cnt), .i_in_dat(in_dat),
        .o_in_rdy(in_rdy), .o_out_vld(out_vld), .o_out_dat(out_dat), .o_out_keep(out_keep),
        .i_out_rdy(out_rdy), .i_flush(flush), .o_lvl(lvl), .o_err_ovf(err_ovf), .i_err_clr(err_clr)
    );

    pe_out_gather_fifo #(.DEPTH(3)) u_dut12 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_vld(in_vld), .i_in_cnt(in_cnt), .i_in_dat(in_dat),
        .o_in_rdy(in_rdy12), .o_out_vld(out_vld12), .o_out_dat(out_dat12), .o_out_keep(out_keep12),
        .i_out_rdy(out_rdy), .i_flush(flush), .o_lvl(lvl12), .o_err_ovf(err_ovf12), .i_err_clr(err_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] n, input logic [3:0] a, input logic [3:0] b);
        in_vld = 1'b1;
        in_cnt = n;
        in_dat = {b, a};
        tick();
        in_vld = 1'b0;
        in_cnt = 2'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_rdy: got %b want 1", in_rdy); end
        n_chk++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld: got %b want 0", out_vld); end
        n_chk++; if (out_keep !== 4'h0) begin n_fail++; $display("FAIL reset_keep: got %h want 0", out_keep); end
        n_chk++; if (lvl !== 4'd0) begin n_fail++; $display("FAIL reset_lvl: got %0d want 0", lvl); end
        n_chk++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_ovf); end
    endtask

    task automatic test_basic();
        out_rdy = 1'b1;
        push(2, 4'h0, 4'h1);
        n_chk++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL basic_half_vld: got %b want 0", out_vld); end
        push(2, 4'h2, 4'h3);
        n_chk++; if (out_vld !== 1'b1) begin n_fail++; $display("FAIL basic_vld: got %b want 1", out_vld); end
        n_chk++; if (out_dat !== 16'h3210) begin n_fail++; $display("FAIL basic_dat: got %h want 3210", out_dat); end
        n_chk++; if (out_keep !== 4'hF) begin n_fail++; $display("FAIL basic_keep: got %h want f", out_keep); end
        n_chk++; if (lvl !== 4'd4) begin n_fail++; $display("FAIL basic_lvl4: got %0d want 4", lvl); end
        tick();
        n_chk++; if (lvl !== 4'd0) begin n_fail++; $display("FAIL basic_lvl0: got %0d want 0", lvl); end
        n_chk++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL basic_drained_vld: got %b want 0", out_vld); end
        out_rdy = 1'b0;
    endtask

    task automatic test_mixed();
        out_rdy = 1'b0;
        push(1, 4'h0, 4'h0);
        push(2, 4'h1, 4'h2);
        push(1, 4'h3, 4'h0);
        push(2, 4'h4, 4'h5);
        n_chk++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL mixed_rdy_at6: got %b want 1", in_rdy); end
        push(2, 4'h6, 4'h7);
        n_chk++; if (lvl !== 4'd8) begin n_fail++; $display("FAIL mixed_lvl8: got %0d want 8", lvl); end
        n_chk++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL mixed_rdy_full: got %b want 0", in_rdy); end
        n_chk++; if (out_dat !== 16'h3210) begin n_fail++; $display("FAIL mixed_word0: got %h want 3210", out_dat); end
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        n_chk++; if (out_dat !== 16'h7654) begin n_fail++; $display("FAIL mixed_word1: got %h want 7654", out_dat); end
        n_chk++; if (lvl !== 4'd4) begin n_fail++; $display("FAIL mixed_lvl4: got %0d want 4", lvl); end
        push(2, 4'h8, 4'h9);
        push(2, 4'hA, 4'hB);
        n_chk++; if (lvl !== 4'd8) begin n_fail++; $display("FAIL mixed_refill: got %0d want 8", lvl); end
        out_rdy = 1'b1;
        tick();
        n_chk++; if (out_dat !== 16'hBA98) begin n_fail++; $display("FAIL mixed_wrapword: got %h want ba98", out_dat); end
        tick();
        n_chk++; if (lvl !== 4'd0) begin n_fail++; $display("FAIL mixed_empty: got %0d want 0", lvl); end
        out_rdy = 1'b0;
    endtask

    task automatic test_flush();
        push(2, 4'hA, 4'hB);
        push(1, 4'hC, 4'h0);
        out_rdy = 1'b1;
        flush = 1'b0;
        #1;
        n_chk++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL flush_off_vld: got %b want 0", out_vld); end
        n_chk++; if (lvl !== 4'd3) begin n_fail++; $display("FAIL flush_lvl3: got %0d want 3", lvl); end
        flush = 1'b1;
        #1;
        n_chk++; if (out_vld !== 1'b1) begin n_fail++; $display("FAIL flush_vld: got %b want 1", out_vld); end
        n_chk++; if (out_keep !== 4'h7) begin n_fail++; $display("FAIL flush_keep: got %h want 7", out_keep); end
        n_chk++; if (out_dat !== 16'h0CBA) begin n_fail++; $display("FAIL flush_dat: got %h want 0cba", out_dat); end
        tick();
        flush = 1'b0;
        n_chk++; if (lvl !== 4'd0) begin n_fail++; $display("FAIL flush_lvl0: got %0d want 0", lvl); end
        out_rdy = 1'b0;
        push(2, 4'hD, 4'hE);
        push(2, 4'hF, 4'h1);
        n_chk++; if (out_dat !== 16'h1FED) begin n_fail++; $display("FAIL flush_straddle: got %h want 1fed", out_dat); end
        n_chk++; if (out_keep !== 4'hF) begin n_fail++; $display("FAIL flush_straddle_keep: got %h want f", out_keep); end
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        out_rdy = 1'b0;
        push(3, 4'h9, 4'h9);
        n_chk++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_cnt3_err: got %b want 1", err_ovf); end
        n_chk++; if (lvl !== 4'd0) begin n_fail++; $display("FAIL ovf_cnt3_lvl: got %0d want 0", lvl); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_chk++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b want 0", err_ovf); end
        push(0, 4'h9, 4'h9);
        n_chk++; if (lvl !== 4'd0 || err_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_zero_push: got lvl %0d err %b want 0 0", lvl, err_ovf); end
        push(2, 4'h0, 4'h1);
        push(2, 4'h2, 4'h3);
        push(2, 4'h4, 4'h5);
        push(1, 4'h6, 4'h0);
        n_chk++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL ovf_rdy_at7: got %b want 0", in_rdy); end
        push(1, 4'h8, 4'h0);
        n_chk++; if (lvl !== 4'd7) begin n_fail++; $display("FAIL ovf_dropped_lvl: got %0d want 7", lvl); end
        n_chk++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_full_err: got %b want 1", err_ovf); end
        err_clr = 1'b1;
        push(1, 4'h8, 4'h0);
        n_chk++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b want 1", err_ovf); end
        tick();
        err_clr = 1'b0;
        n_chk++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr2: got %b want 0", err_ovf); end
        n_chk++; if (out_dat !== 16'h3210) begin n_fail++; $display("FAIL ovf_data_intact: got %h want 3210", out_dat); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_rdy = 1'b0;
        push(2, 4'h0, 4'h1);
        push(2, 4'h2, 4'h3);
        push(1, 4'h4, 4'h0);
        out_rdy = 1'b1;
        push(2, 4'h5, 4'h6);
        n_chk++; if (lvl !== 4'd3) begin n_fail++; $display("FAIL b2b_lvl: got %0d want 3", lvl); end
        n_chk++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL b2b_vld: got %b want 0", out_vld); end
        flush = 1'b1;
        #1;
        n_chk++; if (out_dat !== 16'h0654 || out_keep !== 4'h7) begin n_fail++; $display("FAIL b2b_order: got %h/%h want 0654/7", out_dat, out_keep); end
        tick();
        flush = 1'b0;
        out_rdy = 1'b0;
        n_chk++; if (lvl !== 4'd0) begin n_fail++; $display("FAIL b2b_empty: got %0d want 0", lvl); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_rdy = 1'b0;
        push(2, 4'h1, 4'h2);
        push(2, 4'h3, 4'h4);
        push(2, 4'h5, 4'h6);
        n_chk++; if (lvl !== 4'd6 || out_vld !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got lvl %0d vld %b want 6 1", lvl, out_vld); end
        do_reset();
        n_chk++; if (lvl !== 4'd0) begin n_fail++; $display("FAIL rstmid_lvl: got %0d want 0", lvl); end
        n_chk++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL rstmid_vld: got %b want 0", out_vld); end
        n_chk++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL rstmid_rdy: got %b want 1", in_rdy); end
    endtask

    task automatic test_cap12();
        do_reset();
        out_rdy = 1'b0;
        push(2, 4'h0, 4'h1);
        push(2, 4'h2, 4'h3);
        push(2, 4'h4, 4'h5);
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        n_chk++; if (lvl12 !== 4'd2) begin n_fail++; $display("FAIL cap12_lvl2: got %0d want 2", lvl12); end
        push(2, 4'h6, 4'h7);
        push(2, 4'h8, 4'h9);
        push(2, 4'hA, 4'hB);
        push(2, 4'hC, 4'hD);
        n_chk++; if (in_rdy12 !== 1'b1) begin n_fail++; $display("FAIL cap12_rdy_at10: got %b want 1", in_rdy12); end
        push(2, 4'hE, 4'hF);
        n_chk++; if (lvl12 !== 4'd12 || in_rdy12 !== 1'b0) begin n_fail++; $display("FAIL cap12_full: got lvl %0d rdy %b want 12 0", lvl12, in_rdy12); end
        n_chk++; if (out_dat12 !== 16'h7654) begin n_fail++; $display("FAIL cap12_w1: got %h want 7654", out_dat12); end
        out_rdy = 1'b1;
        tick();
        n_chk++; if (out_dat12 !== 16'hBA98) begin n_fail++; $display("FAIL cap12_w2: got %h want ba98", out_dat12); end
        tick();
        n_chk++; if (out_dat12 !== 16'hFEDC) begin n_fail++; $display("FAIL cap12_wrap: got %h want fedc", out_dat12); end
        n_chk++; if (lvl12 !== 4'd4) begin n_fail++; $display("FAIL cap12_lvl4: got %0d want 4", lvl12); end
        tick();
        out_rdy = 1'b0;
        n_chk++; if (lvl12 !== 4'd0 || out_vld12 !== 1'b0) begin n_fail++; $display("FAIL cap12_empty: got lvl %0d vld %b want 0 0", lvl12, out_vld12); end
    endtask

    initial begin
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        in_cnt  = 2'd0;
        in_dat  = '0;
        out_rdy = 1'b0;
        flush   = 1'b0;
        err_clr = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_mixed();
        test_flush();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_cap12();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pe_out_gather_fifo.md
Name: pe_out_gather_fifo

Overview:
- Next-generation PE output FIFO for the systolic array.
- Gathers a variable number of elements per cycle (0..WR_LANES) from a PE column and emits RD_LANES-wide words to the result writer using a valid/ready handshake.
- Generalised in lane counts and depth; adds backpressure (in_rdy), flush-driven partial-word drain with a keep mask, a fill-level output and a sticky overflow flag.

Parameters:
- WIDTH, 4, bits per element
- WR_LANES, 2, maximum elements pushed per cycle
- RD_LANES, 4, elements per output word
- DEPTH, 2, capacity in output words; CAP = DEPTH*RD_LANES elements (CAP >= WR_LANES + RD_LANES; need not be a power of 2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_vld  in  1  push request
- in_cnt  in  $clog2(WR_LANES+1)  elements in this push; lanes 0..in_cnt-1 are valid
- in_dat  in  [WR_LANES][WIDTH]  push data, lane 0 oldest
- in_rdy  out  1  space for WR_LANES elements
- out_vld  out  1  output word valid
- out_dat  out  [RD_LANES][WIDTH]  output word, lane 0 oldest
- out_keep  out  RD_LANES  valid-lane mask for out_dat
- out_rdy  in  1  consumer accepts word
- flush  in  1  level: drain any partial word
- lvl  out  $clog2(CAP+1)  current element count
- err_ovf  out  1  sticky: push attempted while !in_rdy or with in_cnt > WR_LANES
- err_clr  in  1  clears err_ovf

Behaviour:
- Element-granular circular buffer, mem[CAP]; wptr and rptr are element indices in 0..CAP-1 and wrap modulo CAP by compare/subtract, with no power-of-2 masking; cnt is held in a register.
- Reset (rst_n=0 at posedge): wptr=rptr=cnt=0 and err_ovf=0. Outputs then read in_rdy=1, out_vld=0, out_keep=0, lvl=0. Contents of mem are don't-care and need not be reset. Reset mid-stream discards all data; there is no partial drain.
- in_rdy = (CAP - cnt) >= WR_LANES, computed from registered cnt only; it is independent of the same-cycle pop.
- Push fires when in_vld & in_rdy & in_cnt != 0 & in_cnt <= WR_LANES.
  - mem[(wptr+i) mod CAP] <= in_dat[i] for i < in_cnt.
  - wptr advances by in_cnt with wrap.
- Illegal push: in_vld & (!in_rdy | in_cnt > WR_LANES) is dropped with no state change and sets err_ovf. err_clr clears err_ovf; if err_clr and a new error occur in the same cycle, set wins.
- Output is combinational from registers: out_dat[i] = mem[(rptr+i) mod CAP].
  - Full word: cnt >= RD_LANES gives out_vld=1 and out_keep=all ones.
  - Partial word: flush=1 and 0 < cnt < RD_LANES gives out_vld=1 and out_keep = (1<<cnt)-1. Lanes with keep=0 are driven 0.
  - Otherwise out_vld=0 and out_keep=0.
- Pop fires when out_vld & out_rdy; it retires popcount(out_keep) elements and rptr advances by that amount with wrap.
- Latency: an element pushed at edge t is visible on out_dat after edge t. A full word needs no flush.
- Simultaneous push and pop: cnt <= cnt + pushed - popped. A pushed element is never popped in the same cycle.
- out_dat and out_keep stay stable while out_vld & !out_rdy, except that flush deassertion may withdraw a partial word. Consumers must hold flush until the partial word is accepted.
- Invariant: 0 <= cnt <= CAP, and lvl = cnt.

Decomposition:
- Package pe_fifo_pkg:
  - elem_t (logic [WIDTH-1:0])
  - function wrap_add(ptr, inc, CAP)
  - function popcount for the keep mask
- One sub-module, pe_fifo_ring: the mem array, pointer pair, and multi-lane write/read index generation.
- The top level holds the count, handshakes, flush/keep logic and the error flag.

Test Plan:
- Reset, then push in_cnt=2 with data {1,0}, then {3,2} -> out_vld=1 the cycle after the second push, out_dat={3,2,1,0}, keep=4'hF; with out_rdy=1, lvl goes 4 -> 0.
- Mixed pushes of 1,2,1,2,2 elements (values 0..7), out_rdy=0 -> lvl=8, in_rdy=0; pops return {3,2,1,0} then {7,6,5,4}, with correct data across the pointer wrap.
- Push 3 elements {A,B,C}, out_rdy=1, flush=0 -> out_vld=0. Raise flush -> out_vld=1, keep=4'h7, out_dat={0,C,B,A}; after the pop, lvl=0.
- At lvl=7 (in_rdy=0), push in_cnt=1 -> dropped, lvl stays 7, err_ovf=1. Pulse err_clr -> err_ovf=0. Push in_cnt=3 with WR_LANES=2 -> err_ovf=1.
- Concurrent push and pop at lvl=5: push 2, pop 4 -> lvl=3 next cycle, with data order preserved.
- Assert rst_n=0 at lvl=6 with out_vld=1 -> next cycle lvl=0, out_vld=0, in_rdy=1. Rerun with CAP=12 (DEPTH=3) to check non-power-of-2 wrap.
